univ_shift_ctrl: RTL
====================

Name: univ_shift_ctrl

Overview:
Sequencing controller for the 9-bit universal shift datapath. It drives two external universal registers through mode lines:
- POS: the one-hot position register, rotated by the encoder.
- RES: the result register, loaded from POS and then shifted for x2/x4 and /2 /4.

It arbitrates between encoder step events and debounced operation requests, and hands the finished result to the display digit decoder through a valid/ack handshake.

Parameters:
PEND_W, 3, width of the signed pending-step counter; it saturates at +/-(2^(PEND_W-1)-1).
ACK_TIMEOUT, 50_000_000, cycles that RES_VALID waits for RES_ACK before the result is dropped (1 s at 50 MHz).

Ports:
CLK  in  1  system clock, 50 MHz.
RST  in  1  reset, asynchronous, active-high.
STEP_CW  in  1  one-cycle pulse: encoder moved clockwise.
STEP_CCW  in  1  one-cycle pulse: encoder moved anti-clockwise.
OP_REQ  in  1  one-cycle pulse: start the operation selected by OP_SEL.
OP_SEL  in  2  00 = x2, 01 = x4, 10 = /2, 11 = /4; sampled only when OP_REQ is accepted.
RES_ACK  in  1  consumer has taken the result.
POS_MODE  out  2  POS register control: 00 HOLD, 01 SHR (rotate toward LSB), 10 SHL (rotate toward MSB), 11 LOAD (unused, never driven).
RES_MODE  out  2  RES register control, same encoding as POS_MODE.
BUSY  out  1  high in any state other than IDLE.
RES_VALID  out  1  result in RES is final.
OP_ERR  out  1  one-cycle pulse: OP_REQ was rejected.

Behaviour:
- All outputs are registered; they change only on the CLK edge or on RST.
- RST (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - POS_MODE = 00, RES_MODE = 00, BUSY = 0, RES_VALID = 0, OP_ERR = 0.
  - Pending counter = 0, op-pending flag = 0, timeout counter = 0.
- Pending counter PEND, updated every cycle in every state:
  - PEND' = PEND + STEP_CW - STEP_CCW - DRAIN, where DRAIN = sign(PEND) in the cycle the FSM enters ROT, else 0.
  - STEP_CW and STEP_CCW in the same cycle cancel.
  - Increments past the maximum are dropped; decrements past the minimum are dropped.
- States: IDLE, ROT, COPY, SHIFT, DONE.
  - IDLE:
    - If PEND != 0, go to ROT. Latch DIR = sign(PEND) and drain one step.
    - If PEND == 0 and an op is pending (OP_REQ this cycle or the op-pending flag set), go to COPY. Latch N = OP_SEL[0] + 1 and SDIR = OP_SEL[1] (1 = right). Clear the op-pending flag.
    - OP_REQ while PEND != 0: latch the op into the op-pending flag. The op therefore sees every step received before it.
  - ROT: one cycle. POS_MODE = 10 if DIR is positive (CW), 01 if negative (CCW). Then return to IDLE.
  - COPY: one cycle, RES_MODE = 11. Then go to SHIFT.
  - SHIFT: N cycles. RES_MODE = 01 if SDIR = 1, else 10. The counter decrements each cycle; at 0, go to DONE.
  - DONE:
    - RES_VALID = 1 and RES_MODE = 00.
    - On RES_ACK, or when the timeout counter reaches ACK_TIMEOUT-1: RES_VALID falls at the next edge and the FSM returns to IDLE.
    - The timeout counter clears on leaving DONE.
- Latency: OP_REQ accepted in IDLE with PEND == 0 at edge t:
  - COPY at t+1.
  - SHIFT from t+2 to t+1+N.
  - RES_VALID first high at t+2+N.
- Rejection: OP_REQ while BUSY, or while the op-pending flag is already set, pulses OP_ERR for one cycle. The active op is unaffected.
- Steps during COPY/SHIFT/DONE only accumulate in PEND. They are drained one per ROT visit, each followed by a return to IDLE (2 cycles per step), after DONE exits.
- POS_MODE and RES_MODE are never non-HOLD in the same cycle.
- RES_ACK outside DONE is ignored.

Decomposition:
- Shared package holds:
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - op encodings OP_X2, OP_X4, OP_DIV2, OP_DIV4;
  - the state encoding.
- One sub-module, step_accum: the saturating signed PEND counter with CW/CCW/drain inputs and sign/zero outputs.

Test Plan:
- RST mid-SHIFT (op /4, second shift cycle) -> all outputs 0 immediately; IDLE next cycle; a later OP_REQ starts cleanly.
- PEND=0, OP_REQ with OP_SEL=01, bench POS=0x004 -> RES_MODE sequence 11,10,10, then RES_VALID at t+4; bench RES = 0x010 (16).
- Two STEP_CW pulses, then OP_REQ with OP_SEL=10 in the cycle after the second pulse, POS initially 0x008 -> two ROT cycles with POS_MODE=10 (POS=0x020), op latched as pending; COPY only after PEND=0; RES = 0x010.
- STEP_CW and STEP_CCW in the same cycle -> PEND unchanged, no ROT.
- Five STEP_CCW pulses during DONE with PEND_W=3 -> PEND saturates at -3; exactly three ROT cycles with POS_MODE=01 after RES_ACK.
- OP_REQ during SHIFT -> OP_ERR one cycle, active result unchanged. With ACK_TIMEOUT=8 and no RES_ACK -> RES_VALID high exactly 8 cycles, then IDLE.

Source files
------------

// File: rtl/univ_shift_ctrl_pkg.sv
// univ_shift_ctrl_pkg: shared register-mode and op encodings plus the controller state encoding
package univ_shift_ctrl_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    localparam logic [1:0] OP_X2     = 2'b00;
    localparam logic [1:0] OP_X4     = 2'b01;
    localparam logic [1:0] OP_DIV2   = 2'b10;
    localparam logic [1:0] OP_DIV4   = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_ROT, S_COPY, S_SHIFT, S_DONE} state_e;
endpackage

// File: rtl/univ_shift_ctrl_step_accum.sv
// step_accum: saturating signed count of encoder steps still to be applied to POS
module step_accum #(
    parameter int PEND_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cw_i,
    input  logic ccw_i,
    input  logic drain_i,
    output logic neg_o,
    output logic zero_o
);
    localparam logic signed [PEND_W+1:0] PMAX = (PEND_W+2)'(2 ** (PEND_W - 1) - 1);
    logic signed [PEND_W-1:0] pend_q, pend_d;
    logic signed [PEND_W+1:0] ext, dn, sum;
    assign neg_o  = pend_q[PEND_W-1];
    assign zero_o = pend_q == '0;
    always_comb begin
        ext    = (PEND_W+2)'(pend_q);
        dn     = !drain_i || zero_o ? '0 : neg_o ? '1 : (PEND_W+2)'(1);
        sum    = ext + (PEND_W+2)'(cw_i) - (PEND_W+2)'(ccw_i) - dn;
        pend_d = PEND_W'(sum > PMAX ? PMAX : sum < -PMAX ? -PMAX : sum);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) pend_q <= '0;
        else pend_q <= pend_d;
endmodule

// File: rtl/univ_shift_ctrl.sv
// univ_shift_ctrl: sequences POS rotations and RES load/shift ops, then hands RES off via valid/ack
module univ_shift_ctrl
    import univ_shift_ctrl_pkg::*;
#(
    parameter int PEND_W      = 3,
    parameter int ACK_TIMEOUT = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STEP_CW,
    input  logic       STEP_CCW,
    input  logic       OP_REQ,
    input  logic [1:0] OP_SEL,
    input  logic       RES_ACK,
    output logic [1:0] POS_MODE,
    output logic [1:0] RES_MODE,
    output logic       BUSY,
    output logic       RES_VALID,
    output logic       OP_ERR
);
    localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
    state_e          state_q, state_d;
    logic            sdir_q, sdir_d, opp_q, opp_d, err_q, err_d, drain, pend_neg, pend_zero;
    logic [1:0]      cnt_q, cnt_d, op_q, op_d, sel, pos_mode_q, pos_mode_d, res_mode_q, res_mode_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    step_accum #(.PEND_W(PEND_W)) u_acc (
        .clk     (CLK),
        .rst     (RST),
        .cw_i    (STEP_CW),
        .ccw_i   (STEP_CCW),
        .drain_i (drain),
        .neg_o   (pend_neg),
        .zero_o  (pend_zero)
    );
    always_comb begin
        state_d = state_q;
        sdir_d  = sdir_q;
        cnt_d   = cnt_q;
        opp_d   = opp_q;
        op_d    = op_q;
        tmo_d   = '0;
        drain   = 1'b0;
        sel     = opp_q ? op_q : OP_SEL;
        err_d   = OP_REQ && (state_q != S_IDLE || opp_q);
        unique case (state_q)
            S_IDLE: begin
                // steps always win: a request arriving with steps outstanding waits in the pending flag
                if (!pend_zero) begin
                    state_d = S_ROT;
                    drain   = 1'b1;
                    if (OP_REQ && !opp_q) begin
                        opp_d = 1'b1;
                        op_d  = OP_SEL;
                    end
                end else if (OP_REQ || opp_q) begin
                    state_d = S_COPY;
                    cnt_d   = (sel == OP_X4 || sel == OP_DIV4) ? 2'd2 : 2'd1;
                    sdir_d  = sel == OP_DIV2 || sel == OP_DIV4;
                    opp_d   = 1'b0;
                end
            end
            S_ROT:   state_d = S_IDLE;
            S_COPY:  state_d = S_SHIFT;
            S_SHIFT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = S_DONE;
            end
            S_DONE: begin
                if (RES_ACK || tmo_q == TW'(ACK_TIMEOUT - 1)) state_d = S_IDLE;
                else tmo_d = tmo_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        pos_mode_d = state_d == S_ROT ? (pend_neg ? MODE_SHR : MODE_SHL) : MODE_HOLD;
        res_mode_d = state_d == S_COPY ? MODE_LOAD :
                     state_d == S_SHIFT ? (sdir_d ? MODE_SHR : MODE_SHL) : MODE_HOLD;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q    <= S_IDLE;
            sdir_q     <= 1'b0;
            cnt_q      <= '0;
            opp_q      <= 1'b0;
            op_q       <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            pos_mode_q <= MODE_HOLD;
            res_mode_q <= MODE_HOLD;
        end else begin
            state_q    <= state_d;
            sdir_q     <= sdir_d;
            cnt_q      <= cnt_d;
            opp_q      <= opp_d;
            op_q       <= op_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            pos_mode_q <= pos_mode_d;
            res_mode_q <= res_mode_d;
        end
    assign POS_MODE  = pos_mode_q;
    assign RES_MODE  = res_mode_q;
    assign BUSY      = state_q != S_IDLE;
    assign RES_VALID = state_q == S_DONE;
    assign OP_ERR    = err_q;
endmodule
